// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the pipeline MEM stage.
// Captures one request, waits LATENCY cycles, then acks with load data or a fault.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        i_memReq,
    input  logic        i_memWrite,
    input  logic [1:0]  i_memSize,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_busy
);

    localparam int unsigned IdxWidth = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CntInit  = 4'(LATENCY - 1);

    typedef enum logic {StIdle, StWait} stateT;

    stateT       stateQ;
    logic [3:0]  cntQ;
    logic        ackQ;
    logic [31:0] addrQ;
    logic [1:0]  sizeQ;
    logic        writeQ;
    logic [31:0] wdataQ;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]         wordOff;
    logic [IdxWidth-1:0] wordIdx;
    logic                fault;
    logic                ackCycle;
    logic [31:0]         readWord;
    logic [31:0]         shifted;
    logic [31:0]         loadData;
    logic [31:0]         storeData;
    logic [3:0]          laneMask;

    // Word offset from the array base; upper bits feed the range check.
    assign wordOff = 30'((addrQ - BASE_ADDR) >> 2);
    assign wordIdx = wordOff[IdxWidth-1:0];

    always_comb begin
        fault = 1'b0;
        case (sizeQ)
            2'b00:   fault = 1'b0;
            2'b01:   fault = addrQ[0];
            2'b10:   fault = |addrQ[1:0];
            default: fault = 1'b1;
        endcase
        if (addrQ < BASE_ADDR) begin
            fault = 1'b1;
        end
        if ({2'b00, wordOff} >= DEPTH_WORDS) begin
            fault = 1'b1;
        end
    end

    assign readWord  = mem[wordIdx];
    assign shifted   = readWord >> {addrQ[1:0], 3'b000};
    assign storeData = wdataQ << {addrQ[1:0], 3'b000};

    always_comb begin
        loadData = shifted;
        laneMask = 4'b1111;
        case (sizeQ)
            2'b00: begin
                loadData = {24'h0, shifted[7:0]};
                laneMask = 4'b0001 << addrQ[1:0];
            end
            2'b01: begin
                loadData = {16'h0, shifted[15:0]};
                laneMask = 4'b0011 << {addrQ[1], 1'b0};
            end
            default: begin
                loadData = shifted;
                laneMask = 4'b1111;
            end
        endcase
    end

    // Reset masks the ack cycle so an aborted store can never commit.
    assign ackCycle = ackQ & ~reset_x;
    assign o_ack    = ackCycle;
    assign o_fault  = ackCycle & fault;
    assign o_rdata  = (ackCycle && !writeQ && !fault) ? loadData : 32'h0;
    assign o_busy   = i_memReq & ~o_ack;

    always_ff @(posedge clk) begin
        if (ackCycle && writeQ && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (laneMask[b]) begin
                    mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
                end
            end
        end
    end

    // ackQ tracks (stateQ == StWait && cntQ == 0) one edge ahead.
    always_ff @(posedge clk) begin
        if (reset_x) begin
            stateQ <= StIdle;
            cntQ   <= 4'd0;
            ackQ   <= 1'b0;
        end else begin
            case (stateQ)
                StIdle: begin
                    ackQ <= 1'b0;
                    if (i_memReq) begin
                        addrQ  <= i_addr;
                        sizeQ  <= i_memSize;
                        writeQ <= i_memWrite;
                        wdataQ <= i_wdata;
                        cntQ   <= CntInit;
                        ackQ   <= (CntInit == 4'd0);
                        stateQ <= StWait;
                    end
                end
                StWait: begin
                    if (cntQ != 4'd0) begin
                        cntQ <= cntQ - 4'd1;
                        ackQ <= (cntQ == 4'd1);
                    end else begin
                        ackQ   <= 1'b0;
                        stateQ <= StIdle;
                    end
                end
                default: begin
                    ackQ   <= 1'b0;
                    stateQ <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: dut 0 uses default parameters (LATENCY=2, base 0),
// dut 1 uses LATENCY=1, base 0x1000, 16 words.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req, wr, ack, fault, busy;
    logic [1:0]  sz    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder dut0 (
        .clk        (clk),
        .reset_x    (rst),
        .i_memReq   (req[0]),
        .i_memWrite (wr[0]),
        .i_memSize  (sz[0]),
        .i_addr     (addr[0]),
        .i_wdata    (wd[0]),
        .o_ack      (ack[0]),
        .o_rdata    (rdata[0]),
        .o_fault    (fault[0]),
        .o_busy     (busy[0])
    );

    dmem_responder #(
        .DEPTH_WORDS (16),
        .LATENCY     (1),
        .BASE_ADDR   (32'h0000_1000)
    ) dut1 (
        .clk        (clk),
        .reset_x    (rst),
        .i_memReq   (req[1]),
        .i_memWrite (wr[1]),
        .i_memSize  (sz[1]),
        .i_addr     (addr[1]),
        .i_wdata    (wd[1]),
        .o_ack      (ack[1]),
        .o_rdata    (rdata[1]),
        .o_fault    (fault[1]),
        .o_busy     (busy[1])
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic setReq(input int s, input logic w, input logic [1:0] z, input logic [31:0] a,
                          input logic [31:0] d);
        wr[s]   = w;
        sz[s]   = z;
        addr[s] = a;
        wd[s]   = d;
    endtask

    // Called just after a rising edge with the target dut idle.
    task automatic doAccess(input int s, input logic w, input logic [1:0] z, input logic [31:0] a,
                            input logic [31:0] d, input logic hold, input logic expF,
                            input logic [31:0] expD, input string tag);
        int  n;
        logic done;
        n    = 0;
        done = 1'b0;
        req[s] = 1'b1;
        setReq(s, w, z, a, d);
        @(negedge clk);
        checkVal({tag, ".busyIdle"}, 32'(busy[s]), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            req[s] = 1'b0;
            setReq(s, ~w, ~z, ~a, ~d);
        end
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (ack[s]) begin
                done = 1'b1;
            end else begin
                n++;
                if (hold) checkVal({tag, ".busyWait"}, 32'(busy[s]), 32'd1);
            end
        end
        checkVal({tag, ".acked"}, 32'(done), 32'd1);
        if (done) begin
            checkVal({tag, ".latency"}, 32'(n), (s == 1) ? 32'd0 : 32'd1);
            checkVal({tag, ".busyAck"}, 32'(busy[s]), 32'd0);
            checkVal({tag, ".fault"}, 32'(fault[s]), 32'(expF));
            checkVal({tag, ".rdata"}, rdata[s], expD);
        end
        @(posedge clk);
        #1;
        req[s] = 1'b0;
    endtask

    initial begin
        int acks;
        req = 2'b00;
        setReq(0, 1'b0, 2'b10, 32'h10, 32'h0);
        setReq(1, 1'b0, 2'b10, 32'h1000, 32'h0);

        // Requests held during reset are ignored; outputs stay quiet.
        req[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("rst.ack", 32'(ack[0]), 32'd0);
            checkVal("rst.fault", 32'(fault[0]), 32'd0);
            checkVal("rst.rdata", rdata[0], 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First request accepted in the first cycle out of reset.
        doAccess(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, "stW10");
        doAccess(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, "ldW10");

        // Byte and half lanes.
        doAccess(0, 1'b1, 2'b10, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, "clrW10");
        doAccess(0, 1'b1, 2'b00, 32'h13, 32'h555555AA, 1'b1, 1'b0, 32'h0, "stB13");
        doAccess(0, 1'b1, 2'b01, 32'h10, 32'h77771234, 1'b1, 1'b0, 32'h0, "stH10");
        doAccess(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b1, 1'b0, 32'hAA001234, "ldW10b");
        doAccess(0, 1'b0, 2'b00, 32'h13, 32'h0, 1'b1, 1'b0, 32'h000000AA, "ldB13");
        doAccess(0, 1'b0, 2'b01, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000AA00, "ldH12");
        doAccess(0, 1'b0, 2'b00, 32'h10, 32'h0, 1'b1, 1'b0, 32'h00000034, "ldB10");

        // Misaligned accesses fault and leave the array alone.
        doAccess(0, 1'b0, 2'b10, 32'h12, 32'h0, 1'b1, 1'b1, 32'h0, "ldW12");
        doAccess(0, 1'b1, 2'b01, 32'h11, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, "stH11");
        doAccess(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b1, 1'b0, 32'hAA001234, "ldW10c");

        // Range and reserved-size faults; last word is still in range.
        doAccess(0, 1'b0, 2'b10, 32'h1000, 32'h0, 1'b1, 1'b1, 32'h0, "ldRange");
        doAccess(0, 1'b1, 2'b10, 32'hFFC, 32'h0BADF00D, 1'b1, 1'b0, 32'h0, "stLast");
        doAccess(0, 1'b0, 2'b10, 32'hFFC, 32'h0, 1'b1, 1'b0, 32'h0BADF00D, "ldLast");
        doAccess(0, 1'b0, 2'b11, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, "ldSz11");

        // Reset mid-WAIT aborts the store.
        doAccess(0, 1'b1, 2'b10, 32'h20, 32'h11223344, 1'b1, 1'b0, 32'h0, "stW20");
        req[0] = 1'b1;
        setReq(0, 1'b1, 2'b10, 32'h20, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack[0]) acks++;
        end
        checkVal("abort.noAck", 32'(acks), 32'd0);
        @(posedge clk);
        #1;
        doAccess(0, 1'b0, 2'b10, 32'h20, 32'h0, 1'b1, 1'b0, 32'h11223344, "ldW20");
        doAccess(0, 1'b1, 2'b00, 32'h21, 32'h000000CC, 1'b1, 1'b0, 32'h0, "stB21");
        doAccess(0, 1'b0, 2'b10, 32'h20, 32'h0, 1'b1, 1'b0, 32'h1122CC44, "ldW20b");

        // Inputs scrambled and request dropped after acceptance.
        doAccess(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 1'b0, 32'hAA001234, "ldDrop");

        // Back-to-back on the LATENCY=1 instance.
        req[1] = 1'b1;
        setReq(1, 1'b1, 2'b10, 32'h1000, 32'hA5A5A5A5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkVal($sformatf("b2b.ack%0d", i), 32'(ack[1]), 32'(i % 2));
            checkVal($sformatf("b2b.busy%0d", i), 32'(busy[1]), 32'((i + 1) % 2));
            if (i == 5) checkVal("b2b.rdata", rdata[1], 32'hA5A5A5A5);
            @(posedge clk);
            #1;
            if (i == 1) setReq(1, 1'b1, 2'b10, 32'h1004, 32'h5A5A5A5A);
            if (i == 3) setReq(1, 1'b0, 2'b10, 32'h1000, 32'h0);
            if (i == 5) req[1] = 1'b0;
        end
        doAccess(1, 1'b0, 2'b10, 32'h1004, 32'h0, 1'b0, 1'b0, 32'h5A5A5A5A, "l1Drop");
        doAccess(1, 1'b0, 2'b10, 32'h0FFC, 32'h0, 1'b1, 1'b1, 32'h0, "l1Below");
        doAccess(1, 1'b0, 2'b10, 32'h1040, 32'h0, 1'b1, 1'b1, 32'h0, "l1Above");
        doAccess(1, 1'b1, 2'b10, 32'h103C, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, "l1StTop");
        doAccess(1, 1'b0, 2'b01, 32'h103E, 32'h0, 1'b1, 1'b0, 32'h0000CAFE, "l1LdTop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
